// File: rtl/hub75_column_driver.sv
// hub75_column_driver: requests a column pair, captures it, and drives a 64x64 1/32-scan HUB75 panel with 3-plane BCM; optional HUB75_TIMEOUT_EN re-requests data when WAIT times out
module hub75_column_driver #(
    parameter int NUM_ROWS  = 64,
    parameter int SCAN_RATE = 32,
    parameter int RGB_RES   = 9,
    parameter int BASE_TIME = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in,
    input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]      columns,
    input  logic [$clog2(SCAN_RATE)-1:0]               col_num1,
    input  logic                                       data_valid,
    output logic                                       hub75_ready,
    output logic [$clog2(SCAN_RATE)-1:0]               hub75_addr,
    output logic [2:0]                                 hub75_rgb0,
    output logic [2:0]                                 hub75_rgb1,
    output logic                                       hub75_clk,
    output logic                                       hub75_latch,
    output logic                                       hub75_oe_n
);
    localparam int AW = $clog2(SCAN_RATE);
    localparam int PW = $clog2(NUM_ROWS) + 1;
    localparam int DW = $clog2((BASE_TIME << 2) + 1);

    typedef enum logic [2:0] {S_READY, S_WAIT, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;

    state_t                                state, nxt;
    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] cap;
    logic [AW-1:0]                         cap_addr;
    logic [1:0]                            plane;
    logic [PW-1:0]                         pix;
    logic                                  phase;
    logic [DW-1:0]                         dcnt;
    logic                                  disp_done;
    logic [RGB_RES-1:0]                    sh0, sh1;

    assign disp_done = dcnt == DW'((BASE_TIME << plane) - 1);
    assign sh0 = cap[0][pix[PW-2:0]] >> plane;
    assign sh1 = cap[1][pix[PW-2:0]] >> plane;

`ifdef HUB75_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          tout;
    assign tout = tcnt == TW'(TIMEOUT);

    // WAIT dwell counter, cleared whenever the FSM is not staying in WAIT
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            tcnt <= '0;
        else
            tcnt <= (state == S_WAIT && nxt == S_WAIT) ? tcnt + 1'b1 : '0;
    end
`else
    logic tout;
    assign tout = 1'b0;
`endif

    // state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            state <= S_READY;
        else
            state <= nxt;
    end

    // next state and panel outputs decoded from the current state
    always_comb begin
        nxt         = state;
        hub75_ready = 1'b0;
        hub75_clk   = 1'b0;
        hub75_latch = 1'b0;
        hub75_oe_n  = 1'b1;
        hub75_rgb0  = 3'b000;
        hub75_rgb1  = 3'b000;
        case (state)
            S_READY: begin
                hub75_ready = ~rst_in;
                nxt         = S_WAIT;
            end
            S_WAIT: nxt = data_valid ? S_SHIFT : (tout ? S_READY : S_WAIT);
            S_SHIFT: begin
                hub75_clk  = phase;
                hub75_rgb0 = {sh0[6], sh0[3], sh0[0]};
                hub75_rgb1 = {sh1[6], sh1[3], sh1[0]};
                nxt        = (phase && pix == PW'(NUM_ROWS - 1)) ? S_BLANK : S_SHIFT;
            end
            S_BLANK: nxt = S_LATCH;
            S_LATCH: begin
                hub75_latch = 1'b1;
                nxt         = S_DISPLAY;
            end
            S_DISPLAY: begin
                hub75_oe_n = 1'b0;
                nxt        = disp_done ? (plane == 2'd2 ? S_READY : S_SHIFT) : S_DISPLAY;
            end
            default: nxt = S_READY;
        endcase
    end

    // capture, pixel/plane/display counters and the row address register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cap        <= '0;
            cap_addr   <= '0;
            hub75_addr <= '0;
            plane      <= '0;
            pix        <= '0;
            phase      <= 1'b0;
            dcnt       <= '0;
        end else begin
            if (state == S_WAIT && data_valid) begin
                cap      <= columns;
                cap_addr <= col_num1;
                plane    <= '0;
                pix      <= '0;
                phase    <= 1'b0;
            end
            if (state == S_SHIFT) begin
                phase <= ~phase;
                if (phase)
                    pix <= pix + 1'b1;
            end
            if (state == S_BLANK) begin
                hub75_addr <= cap_addr;
                dcnt       <= '0;
            end
            if (state == S_DISPLAY) begin
                dcnt <= dcnt + 1'b1;
                if (disp_done) begin
                    plane <= plane + 1'b1;
                    pix   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_hub75_column_driver.sv
// tb_hub75_column_driver: randomized self-checking bench comparing panel waveforms to a per-pair expected frame
module tb_hub75_column_driver;
    logic                    clk_in = 1'b0;
    logic                    rst_in = 1'b1;
    logic [1:0][63:0][8:0]   columns = '0;
    logic [4:0]              col_num1 = '0;
    logic                    data_valid = 1'b0;
    logic                    hub75_ready;
    logic [4:0]              hub75_addr;
    logic [2:0]              hub75_rgb0, hub75_rgb1;
    logic                    hub75_clk, hub75_latch, hub75_oe_n;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] exp_up [64];
    logic [8:0] exp_lo [64];
    logic [4:0] last_addr = '0;

    hub75_column_driver #(.TIMEOUT(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .columns(columns), .col_num1(col_num1),
        .data_valid(data_valid), .hub75_ready(hub75_ready), .hub75_addr(hub75_addr),
        .hub75_rgb0(hub75_rgb0), .hub75_rgb1(hub75_rgb1), .hub75_clk(hub75_clk),
        .hub75_latch(hub75_latch), .hub75_oe_n(hub75_oe_n)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] plane_bits(input logic [8:0] px, input int b);
        return {px[6+b], px[3+b], px[b]};
    endfunction

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, hub75_ready, 0);
        check({tag, "_addr"}, hub75_addr, 0);
        check({tag, "_rgb"}, {hub75_rgb0, hub75_rgb1}, 0);
        check({tag, "_clk"}, hub75_clk, 0);
        check({tag, "_latch"}, hub75_latch, 0);
        check({tag, "_oe_n"}, hub75_oe_n, 1);
    endtask

    task automatic send_pair(input logic [4:0] a);
        @(negedge clk_in);
        check("ready_width", hub75_ready, 0);
        for (int p = 0; p < 64; p++) begin
            columns[0][p] = exp_up[p];
            columns[1][p] = exp_lo[p];
        end
        col_num1   = a;
        data_valid = 1'b1;
        @(negedge clk_in);
        data_valid = 1'b0;
    endtask

    task automatic run_pair(input logic [4:0] a, input bit noise);
        int   rdy_k, nl, rgb_bad, addr_bad, hold_bad, seq_bad;
        int   edges [3];
        int   oe [3];
        logic pc;
        send_pair(a);
        rdy_k = -1; nl = 0; rgb_bad = 0; addr_bad = 0; hold_bad = 0; seq_bad = 0; pc = 1'b0;
        for (int b = 0; b < 3; b++) begin
            edges[b] = 0;
            oe[b] = 0;
        end
        for (int k = 0; k < 1000; k++) begin
            if (hub75_ready) begin
                rdy_k = k;
                break;
            end
            if (hub75_clk && !pc) begin
                if (nl > 2 || edges[nl] > 63)
                    seq_bad++;
                else begin
                    if (hub75_rgb0 !== plane_bits(exp_up[edges[nl]], nl) ||
                        hub75_rgb1 !== plane_bits(exp_lo[edges[nl]], nl))
                        rgb_bad++;
                    edges[nl]++;
                end
            end
            if (hub75_latch) begin
                if (hub75_addr !== a || hub75_clk)
                    addr_bad++;
                nl++;
            end else if (nl == 0 && hub75_addr !== last_addr)
                hold_bad++;
            if (!hub75_oe_n) begin
                if (hub75_latch || hub75_clk || nl == 0 || nl > 3)
                    seq_bad++;
                else
                    oe[nl-1]++;
            end
            pc = hub75_clk;
            if (noise) begin
                for (int p = 0; p < 64; p++) begin
                    columns[0][p] = 9'($urandom);
                    columns[1][p] = 9'($urandom);
                end
                col_num1   = 5'($urandom);
                data_valid = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk_in);
        end
        data_valid = 1'b0;
        check("ready_latency", rdy_k, 446);
        check("latch_count", nl, 3);
        for (int b = 0; b < 3; b++) begin
            check($sformatf("edges_p%0d", b), edges[b], 64);
            check($sformatf("oe_len_p%0d", b), oe[b], 8 << b);
        end
        check("rgb_errors", rgb_bad, 0);
        check("latch_addr_errors", addr_bad, 0);
        check("addr_hold_errors", hold_bad, 0);
        check("sequence_errors", seq_bad, 0);
        last_addr = a;
    endtask

    task automatic abort_pair(input logic [4:0] a);
        send_pair(a);
        repeat (158) @(negedge clk_in);
        check("abort_in_shift", {hub75_oe_n, hub75_latch}, 2'b10);
        check("abort_addr", hub75_addr, a);
        #2 rst_in = 1'b1;
        #1 check_reset_outs("async_rst");
        repeat (2) @(negedge clk_in);
        check_reset_outs("held_rst");
        rst_in = 1'b0;
        #1 check("ready_after_rst", hub75_ready, 1);
        last_addr = '0;
    endtask

    task automatic fill_random;
        for (int p = 0; p < 64; p++) begin
            exp_up[p] = 9'($urandom);
            exp_lo[p] = 9'($urandom);
        end
    endtask

    initial begin
        int pulses, dark_bad, k;
        repeat (3) @(negedge clk_in);
        check_reset_outs("reset");
        rst_in = 1'b0;
        #1 check("first_ready", hub75_ready, 1);
        check("first_ready_oe_n", hub75_oe_n, 1);

        for (int p = 0; p < 64; p++) begin
            exp_up[p] = 9'h1FF;
            exp_lo[p] = 9'h1FF;
        end
        run_pair(5'd5, 1'b0);

        for (int p = 0; p < 64; p++) begin
            exp_up[p] = 9'b100_010_001;
            exp_lo[p] = 9'd0;
        end
        run_pair(5'($urandom_range(1, 31)), 1'b0);

        fill_random();
        run_pair(5'($urandom), 1'b1);
        fill_random();
        run_pair(5'($urandom), 1'b0);

        fill_random();
        abort_pair(5'($urandom_range(1, 31)));
        fill_random();
        run_pair(5'($urandom), 1'b1);

        dark_bad = 0;
`ifdef HUB75_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            k = 0;
            do begin
                @(negedge clk_in);
                k++;
                if (!hub75_oe_n || hub75_latch) dark_bad++;
            end while (!hub75_ready && k < 100);
            check("timeout_period", k, 18);
        end
`else
        pulses = 0;
        repeat (3000) begin
            @(negedge clk_in);
            if (hub75_ready) pulses++;
            if (!hub75_oe_n || hub75_latch) dark_bad++;
        end
        check("no_timeout_pulses", pulses, 0);
`endif
        check("wait_dark", dark_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
